alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the 10-bit combinational ALU.
- Accepts one operation per handshake and returns a registered result with status flags.
- Adds AND/OR ops and an iterative shift-add multiplier.
- Sits between the register-file read stage and the write-back mux; valid/ready on both sides.

Parameters:
- WIDTH, 10, operand/result width in bits (legal values ≥ 4).
- SHW, $clog2(WIDTH), number of shift-amount bits taken from rs.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- opcode  in  3  0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 NOR, 5 AND, 6 OR, 7 MUL
- rs  in  WIDTH  operand A; shift amount for SHL/SHR
- rt  in  WIDTH  operand B; value shifted for SHL/SHR
- cin  in  1  carry-in for ADD
- bin  in  1  borrow-in for SUB
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  low result
- result_hi  out  WIDTH  MUL upper half; 0 for all other ops
- cout  out  1  ADD carry-out; 0 otherwise
- bout  out  1  SUB borrow-out; 0 otherwise
- zero  out  1  result == 0 (low half only)
- illegal  out  1  opcode 7 issued with the multiplier compiled out

Behaviour:
- One clock, asynchronous active-low reset.
  - On reset: state IDLE, out_valid 0, all result/flag outputs 0, multiplier counter 0.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - Operands are captured at acceptance; later input changes have no effect.
  - Once out_valid is asserted, result, result_hi and all flags stay stable until out_valid && out_ready.
- States:
  - IDLE -> DONE on accept of a non-MUL op.
  - IDLE -> MUL_BUSY on accept of MUL.
  - MUL_BUSY -> DONE when the iteration counter reaches WIDTH-1.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE or MUL_BUSY on out_ready with a same-cycle accept (back-to-back).
- Latency:
  - Non-MUL ops: out_valid rises on the first edge after acceptance (1 cycle). Throughput is 1 op/cycle while out_ready is held high.
  - MUL: one partial product per cycle; out_valid rises WIDTH+1 edges after acceptance.
- Arithmetic:
  - ADD: {cout, result} = rs + rt + cin, computed at WIDTH+1 bits.
  - SUB: result = rs - rt - bin mod 2^WIDTH. bout = 1 when rs < rt + bin, unsigned.
  - SHL/SHR: logical shift of rt by rs[SHW-1:0], zero fill. Any amount ≥ WIDTH, or any set bit in rs above SHW, gives result 0.
  - NOR/AND/OR: bitwise over rs and rt.
  - MUL: unsigned; {result_hi, result} = rs * rt, full 2*WIDTH product.
- Boundaries:
  - in_valid while MUL_BUSY: not accepted, because in_ready is 0.
  - out_ready held low: the block stalls in DONE indefinitely and holds its outputs.
  - Reset mid-MUL: the operation is abandoned, outputs go to reset values, no result is produced.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - The MUL datapath and MUL_BUSY state are present.
  - illegal is tied to 0.
- Undefined:
  - Opcode 7 completes as a 1-cycle op with result = 0, result_hi = 0, zero = 1, illegal = 1.
  - No multiplier logic is synthesised.

Decomposition:
- Package alu_seq_pkg holds:
  - the opcode enum (OP_ADD … OP_MUL, 3 bits);
  - the state enum (IDLE, MUL_BUSY, DONE);
  - the default WIDTH localparam.
- Sub-module alu_mul_iter, instantiated only under ALU_SEQ_MUL_EN, contains:
  - the shift-add iteration: accumulator, multiplier shift register, counter;
  - ports start, done, a, b, prod.

Test Plan:
- ADD rs=3, rt=5, cin=1, out_ready=1 -> next cycle result=9, cout=0, zero=0; ADD 1023+1, cin=0 -> result=0, cout=1, zero=1.
- SUB rs=3, rt=5, bin=0 -> result=1022, bout=1; SUB rs=10, rt=3 -> result=7, bout=0.
- SHL rt=1 by rs=2 -> result=4; SHR rt=1023 by rs=12 -> result=0; NOR rs=1111111100, rt=0011101100 -> result=0000000011.
- MUL rs=25, rt=41 (macro on) -> in_ready=0 for 10 cycles, out_valid at edge 11, result=1, result_hi=1. With the macro off -> illegal=1, result=0 after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after an ADD -> result stable and in_ready=0. Then out_ready=1 with a queued SUB -> SUB accepted the same cycle and its result appears on the next cycle.
- Assert rst_n=0 at MUL cycle 4 -> outputs return to 0 asynchronously, out_valid never pulses for that MUL, in_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, default width.
// Optional multiplier is enabled with the ALU_SEQ_MUL_EN macro.
package alu_seq_pkg;

    localparam int ALU_WIDTH = 10;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_NOR = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
module alu_mul_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] partial;

    assign partial = mplier[0] ? mcand : '0;
    // prod is the accumulator after this cycle's partial product
    assign prod    = acc + partial;
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and status flags.
// Define ALU_SEQ_MUL_EN to build in the iterative multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cin,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             bout,
    output logic             zero,
    output logic             illegal
);

    state_t state, nxt;
    op_t    op;
    logic   accept;
    logic   is_mul;
    logic   mul_done;

    logic [WIDTH-1:0] alu_res;
    logic             alu_co;
    logic             alu_bo;
    logic             alu_il;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             sh_big;

    assign op        = op_t'(opcode);
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod;

    assign is_mul = (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (rs),
        .b     (rt),
        .done  (mul_done),
        .prod  (prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    // amounts past the width, including high rs bits, flush to zero
    assign sh_big = (|(rs >> SHW)) || (rs[SHW-1:0] > SHW'(WIDTH - 1));

    always_comb begin
        alu_res = '0;
        alu_co  = 1'b0;
        alu_bo  = 1'b0;
        alu_il  = 1'b0;
        sum     = '0;
        diff    = '0;
        unique case (op)
            OP_ADD: begin
                sum     = {1'b0, rs} + {1'b0, rt} + (WIDTH + 1)'(cin);
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
            end
            OP_SUB: begin
                diff    = {1'b0, rs} - {1'b0, rt} - (WIDTH + 1)'(bin);
                alu_res = diff[WIDTH-1:0];
                alu_bo  = diff[WIDTH];
            end
            OP_SHL: alu_res = sh_big ? '0 : (rt << rs[SHW-1:0]);
            OP_SHR: alu_res = sh_big ? '0 : (rt >> rs[SHW-1:0]);
            OP_NOR: alu_res = ~(rs | rt);
            OP_AND: alu_res = rs & rt;
            OP_OR:  alu_res = rs | rt;
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                alu_il = 1'b0;
`else
                alu_il = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) nxt = is_mul ? MUL_BUSY : DONE;
            end
            MUL_BUSY: begin
                if (mul_done) nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) nxt = is_mul ? MUL_BUSY : DONE;
                    else        nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !is_mul) begin
            result    <= alu_res;
            result_hi <= '0;
            cout      <= alu_co;
            bout      <= alu_bo;
            zero      <= ~|alu_res;
            illegal   <= alu_il;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_done) begin
            result    <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
            cout      <= 1'b0;
            bout      <= 1'b0;
            zero      <= ~|prod[WIDTH-1:0];
            illegal   <= 1'b0;
`endif
        end
    end

endmodule
